riscv_regfile_mp: RTL and testbench

//  Parametrised multi-port register file with scoreboard, successor to the single-write/dual-read file.

---
 rtl/riscv_regfile_mp_if.sv | 30 +++
 rtl/riscv_regfile_mp.sv | 115 +++++++++++
 tb/tb_riscv_regfile_mp.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_regfile_mp_if.sv
// Bundles the register-file access signals so that the decode stage (reads,
// allocations) and the writeback stage (writes) share one connection to the
// file. The master drives addresses, data and enables. The slave is the
// register file, which returns read data and scoreboard state.
interface riscv_regfile_mp_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1
);
  logic [NUM_WR-1:0]            wen;
  logic [NUM_WR*ADDR_WIDTH-1:0] waddr;
  logic [NUM_WR*DATA_WIDTH-1:0] wdata;
  logic [NUM_RD*ADDR_WIDTH-1:0] raddr;
  logic [NUM_RD*DATA_WIDTH-1:0] rdata;
  logic [NUM_RD-1:0]            rbusy;
  logic                         alloc_en;
  logic [ADDR_WIDTH-1:0]        alloc_addr;
  logic                         any_busy;

  modport master (
    output wen, waddr, wdata, raddr, alloc_en, alloc_addr,
    input  rdata, rbusy, any_busy
  );

  modport slave (
    input  wen, waddr, wdata, raddr, alloc_en, alloc_addr,
    output rdata, rbusy, any_busy
  );
endinterface

// File: rtl/riscv_regfile_mp.sv
// Multi-port register file with a per-register busy scoreboard.
// - Reads are combinational.
// - When BYPASS is set, a read returns data that is being written in the
//   same cycle.
// - When ZERO_REG is set, register 0 always reads as zero and is never busy.
// - Each register holds a busy bit. An allocation sets the bit and a
//   writeback clears it. If both happen in the same cycle, the allocation
//   wins because it represents the newer producer.
module riscv_regfile_mp #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  riscv_regfile_mp_if.slave   bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};

  logic [DATA_WIDTH-1:0]        regs_r [DEPTH];
  logic [DEPTH-1:0]             busy_r;
  logic [DEPTH-1:0]             busy_nxt_s;
  logic [DEPTH-1:0]             clr_mask_s;
  logic [DEPTH-1:0]             set_mask_s;
  logic [NUM_RD*DATA_WIDTH-1:0] rdata_s;
  logic [NUM_RD-1:0]            rbusy_s;

  // Returns true for the hardwired-zero register when that feature is enabled.
  function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == ZERO_ADDR);
  endfunction

  // Decodes a register index into a one-hot mask.
  function automatic logic [DEPTH-1:0] onehot(input logic [ADDR_WIDTH-1:0] a);
    logic [DEPTH-1:0] v;
    v    = {DEPTH{1'b0}};
    v[a] = 1'b1;
    return v;
  endfunction

  // Updates the register array. Ports are visited in ascending order, so the
  // highest-index port wins when several ports write the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_r[r] <= ZERO_DATA;
      end
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (bus.wen[i] && !is_zero_reg(bus.waddr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
          regs_r[bus.waddr[i*ADDR_WIDTH +: ADDR_WIDTH]] <= bus.wdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Computes the next scoreboard state. Clears come from writebacks and sets
  // come from the allocation. Sets are applied last so that they win.
  always_comb begin
    clr_mask_s = {DEPTH{1'b0}};
    for (int i = 0; i < NUM_WR; i++) begin
      clr_mask_s = clr_mask_s
                 | (onehot(bus.waddr[i*ADDR_WIDTH +: ADDR_WIDTH]) & {DEPTH{bus.wen[i]}});
    end
    set_mask_s    = onehot(bus.alloc_addr) & {DEPTH{bus.alloc_en}};
    busy_nxt_s    = (busy_r & ~clr_mask_s) | set_mask_s;
    busy_nxt_s[0] = (ZERO_REG != 0) ? 1'b0 : busy_nxt_s[0];
  end

  // Holds the scoreboard busy bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= {DEPTH{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [ADDR_WIDTH-1:0] raddr_s;
    logic [DATA_WIDTH-1:0] data_s;
    logic                  mask_s;

    assign raddr_s = bus.raddr[j*ADDR_WIDTH +: ADDR_WIDTH];
    // Outputs are forced low while reset is held and for the zero register.
    assign mask_s  = !rst_n || is_zero_reg(raddr_s);

    // Starts from the stored value. When bypass is enabled, each matching
    // write port overrides it in ascending order, so the highest index wins.
    always_comb begin
      data_s = regs_r[raddr_s];
      for (int i = 0; i < NUM_WR; i++) begin
        data_s = ((BYPASS != 0) && bus.wen[i]
                  && (bus.waddr[i*ADDR_WIDTH +: ADDR_WIDTH] == raddr_s))
               ? bus.wdata[i*DATA_WIDTH +: DATA_WIDTH] : data_s;
      end
    end

    assign rdata_s[j*DATA_WIDTH +: DATA_WIDTH] = mask_s ? ZERO_DATA : data_s;
    // rbusy follows the registered state only; a write in the same cycle
    // does not clear it early.
    assign rbusy_s[j] = mask_s ? 1'b0 : busy_r[raddr_s];
  end

  assign bus.rdata    = rdata_s;
  assign bus.rbusy    = rbusy_s;
  assign bus.any_busy = |busy_r;

endmodule

// File: tb/tb_riscv_regfile_mp.sv
module tb_riscv_regfile_mp;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 3;
  localparam int NW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_regfile_mp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW)) bus_a ();
  riscv_regfile_mp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(1), .NUM_WR(1)) bus_b ();

  riscv_regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW),
                     .ZERO_REG(1), .BYPASS(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  riscv_regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(1), .NUM_WR(1),
                     .ZERO_REG(1), .BYPASS(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard entries: kind 0 rdata_a, 1 rbusy_a, 2 any_busy_a, 3 rdata_b
  string       tag_q[$];
  int          kind_q[$];
  int          port_q[$];
  logic [31:0] exp_q[$];

  // Reference model for dut_a
  logic [31:0] mreg [32];
  logic [31:0] mbusy;

  task automatic expect_val(input string tag, input int kind, input int port, input logic [31:0] v);
    tag_q.push_back(tag); kind_q.push_back(kind); port_q.push_back(port); exp_q.push_back(v);
  endtask

  function automatic logic [31:0] observe(input int kind, input int port);
    case (kind)
      0: return bus_a.rdata[port*DW +: DW];
      1: return {31'd0, bus_a.rbusy[port]};
      2: return {31'd0, bus_a.any_busy};
      3: return bus_b.rdata[DW-1:0];
      default: return 32'hXXXX_XXXX;
    endcase
  endfunction

  task automatic settle_and_check;
    string t; int k; int p; logic [31:0] e; logic [31:0] o;
    #2;
    while (tag_q.size() > 0) begin
      t = tag_q.pop_front(); k = kind_q.pop_front(); p = port_q.pop_front(); e = exp_q.pop_front();
      o = observe(k, p);
      n_tests++;
      assert (o === e) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", t, o, e);
      end
    end
  endtask

  task automatic idle;
    bus_a.wen = '0; bus_a.waddr = '0; bus_a.wdata = '0; bus_a.raddr = '0;
    bus_a.alloc_en = 1'b0; bus_a.alloc_addr = 5'd0;
    bus_b.wen = '0; bus_b.waddr = '0; bus_b.wdata = '0; bus_b.raddr = '0;
    bus_b.alloc_en = 1'b0; bus_b.alloc_addr = 5'd0;
  endtask

  task automatic wr_a(input int p, input logic [4:0] a, input logic [31:0] d);
    bus_a.wen[p] = 1'b1; bus_a.waddr[p*AW +: AW] = a; bus_a.wdata[p*DW +: DW] = d;
  endtask

  task automatic rd_a(input int j, input logic [4:0] a);
    bus_a.raddr[j*AW +: AW] = a;
  endtask

  task automatic assert_reset;
    rst_n = 1'b0;
    for (int r = 0; r < 32; r++) mreg[r] = 32'd0;
    mbusy = 32'd0;
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    logic [31:0] d;
    d = mreg[a];
    for (int i = 0; i < NW; i++)
      if (bus_a.wen[i] && bus_a.waddr[i*AW +: AW] == a) d = bus_a.wdata[i*DW +: DW];
    if (a == 5'd0 || !rst_n) d = 32'd0;
    return d;
  endfunction

  // One clock edge: the model takes the inputs that are still being driven.
  task automatic tick;
    logic [4:0] a;
    @(posedge clk);
    if (rst_n) begin
      for (int i = 0; i < NW; i++) begin
        a = bus_a.waddr[i*AW +: AW];
        if (bus_a.wen[i]) begin
          if (a != 5'd0) mreg[a] = bus_a.wdata[i*DW +: DW];
          mbusy[a] = 1'b0;
        end
      end
      if (bus_a.alloc_en && bus_a.alloc_addr != 5'd0) mbusy[bus_a.alloc_addr] = 1'b1;
    end
    #1;
  endtask

  initial begin
    logic [4:0] ra;
    for (int r = 0; r < 32; r++) mreg[r] = 32'd0;
    mbusy = 32'd0;
    idle();
    // Reset state
    rd_a(0, 5'd5);
    expect_val("reset_rdata", 0, 0, 32'd0);
    expect_val("reset_any_busy", 2, 0, 32'd0);
    settle_and_check();
    tick();
    rst_n = 1'b1;

    // 1: write r5, allocate r9, then assert reset between edges
    idle(); wr_a(0, 5'd5, 32'h1234_5678); bus_a.alloc_en = 1'b1; bus_a.alloc_addr = 5'd9;
    tick();
    idle(); rd_a(0, 5'd5); rd_a(1, 5'd9);
    expect_val("t1_r5_written", 0, 0, 32'h1234_5678);
    expect_val("t1_r9_busy", 1, 1, 32'd1);
    settle_and_check();
    assert_reset();
    expect_val("t1_r5_in_reset", 0, 0, 32'd0);
    expect_val("t1_r9_busy_in_reset", 1, 1, 32'd0);
    expect_val("t1_any_busy_in_reset", 2, 0, 32'd0);
    settle_and_check();
    tick();
    rst_n = 1'b1;

    // 2: dual write, same address then different addresses
    idle(); wr_a(0, 5'd3, 32'hAAAA_0000); wr_a(1, 5'd3, 32'h5555_FFFF);
    tick();
    idle(); rd_a(0, 5'd3);
    expect_val("t2_same_addr_port1_wins", 0, 0, 32'h5555_FFFF);
    settle_and_check();
    wr_a(0, 5'd1, 32'h1111_1111); wr_a(1, 5'd2, 32'h2222_2222);
    tick();
    idle(); rd_a(0, 5'd1); rd_a(2, 5'd2);
    expect_val("t2_r1", 0, 0, 32'h1111_1111);
    expect_val("t2_r2", 0, 2, 32'h2222_2222);
    settle_and_check();

    // 3: bypass on dut_a, no bypass on dut_b
    bus_b.wen = 1'b1; bus_b.waddr = 5'd7; bus_b.wdata = 32'h0101_0101;
    tick();
    idle();
    bus_b.wen = 1'b1; bus_b.waddr = 5'd7; bus_b.wdata = 32'hDEAD_BEEF; bus_b.raddr = 5'd7;
    wr_a(0, 5'd7, 32'hDEAD_BEEF); rd_a(0, 5'd7);
    expect_val("t3_bypass_a", 0, 0, 32'hDEAD_BEEF);
    expect_val("t3_nobypass_old_b", 3, 0, 32'h0101_0101);
    settle_and_check();
    tick();
    idle(); bus_b.raddr = 5'd7;
    wr_a(0, 5'd7, 32'h0000_0001); wr_a(1, 5'd7, 32'h0000_0002); rd_a(1, 5'd7);
    expect_val("t3_nobypass_new_b", 3, 0, 32'hDEAD_BEEF);
    expect_val("t3_bypass_port1_wins", 0, 1, 32'h0000_0002);
    settle_and_check();
    tick();

    // 4: zero register ignores writes and allocation
    idle(); wr_a(0, 5'd0, 32'hFFFF_FFFF); bus_a.alloc_en = 1'b1; bus_a.alloc_addr = 5'd0; rd_a(0, 5'd0);
    expect_val("t4_r0_no_bypass", 0, 0, 32'd0);
    settle_and_check();
    tick();
    idle(); rd_a(0, 5'd0);
    expect_val("t4_r0_zero", 0, 0, 32'd0);
    expect_val("t4_r0_not_busy", 1, 0, 32'd0);
    expect_val("t4_any_busy", 2, 0, 32'd0);
    settle_and_check();

    // 5: scoreboard set, clear, and set-wins
    bus_a.alloc_en = 1'b1; bus_a.alloc_addr = 5'd10;
    tick();
    idle(); rd_a(0, 5'd10);
    expect_val("t5_busy_set", 1, 0, 32'd1);
    expect_val("t5_any_busy_set", 2, 0, 32'd1);
    settle_and_check();
    wr_a(1, 5'd10, 32'h0A0A_0A0A);
    expect_val("t5_busy_held_during_write", 1, 0, 32'd1);
    settle_and_check();
    tick();
    idle(); rd_a(0, 5'd10);
    expect_val("t5_busy_cleared", 1, 0, 32'd0);
    expect_val("t5_any_busy_cleared", 2, 0, 32'd0);
    settle_and_check();
    wr_a(0, 5'd10, 32'h0B0B_0B0B); bus_a.alloc_en = 1'b1; bus_a.alloc_addr = 5'd10;
    tick();
    idle(); rd_a(0, 5'd10);
    expect_val("t5_set_wins", 1, 0, 32'd1);
    expect_val("t5_data", 0, 0, 32'h0B0B_0B0B);
    settle_and_check();

    // 6: random soak against the model with random async resets
    for (int c = 0; c < 10000; c++) begin
      idle();
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 99) == 0) assert_reset();
      for (int i = 0; i < NW; i++) begin
        bus_a.wen[i] = ($urandom_range(0, 1) == 1);
        bus_a.waddr[i*AW +: AW] = 5'($urandom_range(0, 15));
        bus_a.wdata[i*DW +: DW] = $urandom;
      end
      bus_a.alloc_en = ($urandom_range(0, 1) == 1);
      bus_a.alloc_addr = 5'($urandom_range(0, 15));
      for (int j = 0; j < NR; j++) begin
        ra = 5'($urandom_range(0, 15));
        rd_a(j, ra);
        expect_val($sformatf("soak_rdata%0d_c%0d", j, c), 0, j, exp_read(ra));
        expect_val($sformatf("soak_rbusy%0d_c%0d", j, c), 1, j,
                   {31'd0, rst_n && ra != 5'd0 && mbusy[ra]});
      end
      expect_val($sformatf("soak_any_busy_c%0d", c), 2, 0, {31'd0, rst_n && (|mbusy)});
      settle_and_check();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
